// File: rtl/result_bcd_display.sv
// Six-digit seven-segment display stage: a 16-bit result is converted to five BCD digits
// by a serial double-dabble engine (one bit per clock), plus a one-digit state readout.
module result_bcd_display #(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic [2:0]  state_in,
  output logic        busy,
  output logic        bcd_valid,
  output logic [19:0] bcd_out,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam logic [6:0] BLANK_SEG = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [1:0]  state_reg;
  logic [15:0] last_value_reg;
  logic        pending_reg;
  logic [15:0] shift_data_reg;
  logic [19:0] scratch_reg;
  logic [3:0]  count_reg;
  logic        busy_reg;
  logic        valid_reg;
  logic [19:0] bcd_reg;
  logic [6:0]  digit_seg_reg [5];
  logic [6:0]  state_seg_reg;

  logic [19:0] scratch_adj;
  logic [5:0]  zero_above;
  logic [6:0]  digit_seg_next [5];

  // Active-low pattern {g,f,e,d,c,b,a}; polarity applied at the end.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
    logic [6:0] pattern;
    pattern = 7'h7F;
    if (!blank) begin
      case (digit)
        4'd0:    pattern = 7'b1000000;
        4'd1:    pattern = 7'b1111001;
        4'd2:    pattern = 7'b0100100;
        4'd3:    pattern = 7'b0110000;
        4'd4:    pattern = 7'b0011001;
        4'd5:    pattern = 7'b0010010;
        4'd6:    pattern = 7'b0000010;
        4'd7:    pattern = 7'b1111000;
        4'd8:    pattern = 7'b0000000;
        4'd9:    pattern = 7'b0010000;
        default: pattern = 7'h7F;
      endcase
    end
    return SEG_ACTIVE_LOW ? pattern : ~pattern;
  endfunction

  assign zero_above[5] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_digit
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                      ? scratch_reg[4*gi +: 4] + 4'd3
                                      : scratch_reg[4*gi +: 4];
      // zero_above[k]: digit k and every more significant digit are zero
      assign zero_above[gi] = (scratch_reg[4*gi +: 4] == 4'd0) && zero_above[gi+1];
      if (gi == 0) begin : g_ones
        assign digit_seg_next[gi] = seg_encode(scratch_reg[3:0], 1'b0);
      end else begin : g_upper
        assign digit_seg_next[gi] = seg_encode(scratch_reg[4*gi +: 4],
                                               BLANK_LEADING && zero_above[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_value_reg <= 16'd0;
      pending_reg    <= 1'b1;
      shift_data_reg <= 16'd0;
      scratch_reg    <= 20'd0;
      count_reg      <= 4'd0;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      bcd_reg        <= 20'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending_reg || (value_in != last_value_reg)) begin
            shift_data_reg <= value_in;
            last_value_reg <= value_in;
            scratch_reg    <= 20'd0;
            count_reg      <= 4'd0;
            pending_reg    <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch_reg, shift_data_reg} <= {scratch_adj[18:0], shift_data_reg, 1'b0};
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd15) begin
            state_reg <= LATCH;
          end
        end
        LATCH: begin
          bcd_reg   <= scratch_reg;
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Digit segments load together with bcd_out so both change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        digit_seg_reg[i] <= BLANK_SEG;
      end
      state_seg_reg <= BLANK_SEG;
    end else begin
      if (state_reg == LATCH) begin
        for (int i = 0; i < 5; i++) begin
          digit_seg_reg[i] <= digit_seg_next[i];
        end
      end
      state_seg_reg <= seg_encode({1'b0, state_in}, 1'b0);
    end
  end

  assign busy      = busy_reg;
  assign bcd_valid = valid_reg;
  assign bcd_out   = bcd_reg;
  assign hex0      = digit_seg_reg[0];
  assign hex1      = digit_seg_reg[1];
  assign hex2      = digit_seg_reg[2];
  assign hex3      = digit_seg_reg[3];
  assign hex4      = digit_seg_reg[4];
  assign hex5      = state_seg_reg;

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench for result_bcd_display: two instances (default parameters, and
// no leading-zero blanking with active-high segments) share all inputs.
module tb_result_bcd_display;

  logic        clk;
  logic        reset;
  logic [15:0] value_in;
  logic [2:0]  state_in;

  logic        busy_a, valid_a, busy_b, valid_b;
  logic [19:0] bcd_a, bcd_b;
  logic [6:0]  a0, a1, a2, a3, a4, a5;
  logic [6:0]  b0, b1, b2, b3, b4, b5;

  result_bcd_display #(.BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .value_in(value_in), .state_in(state_in),
    .busy(busy_a), .bcd_valid(valid_a), .bcd_out(bcd_a),
    .hex0(a0), .hex1(a1), .hex2(a2), .hex3(a3), .hex4(a4), .hex5(a5));

  result_bcd_display #(.BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(reset), .value_in(value_in), .state_in(state_in),
    .busy(busy_b), .bcd_valid(valid_b), .bcd_out(bcd_b),
    .hex0(b0), .hex1(b1), .hex2(b2), .hex3(b3), .hex4(b4), .hex5(b5));

  typedef struct {
    logic [15:0] value;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [19:0] to_bcd(input logic [15:0] v);
    logic [19:0] r;
    int          x;
    x = int'(v);
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg(input int d, input bit blank, input bit active_low);
    logic [6:0] table_lo [10];
    logic [6:0] p;
    table_lo = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    p = blank ? 7'h7F : table_lo[d];
    return active_low ? p : ~p;
  endfunction

  // {hex4..hex0} expected for a value under the given parameters
  function automatic logic [34:0] digits(input logic [15:0] v, input bit blank_lead,
                                         input bit active_low);
    logic [19:0] b;
    logic [34:0] r;
    bit          all_zero;
    b = to_bcd(v);
    r = '0;
    all_zero = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      all_zero = all_zero && (b[4*k +: 4] == 4'd0);
      r[7*k +: 7] = seg(int'(b[4*k +: 4]), blank_lead && all_zero && (k != 0), active_low);
    end
    return r;
  endfunction

  // Monitor: a falling busy marks a latch edge; compare against the scoreboard head.
  always @(negedge clk) begin
    if (reset && prev_busy && !busy_a) begin
      if (q.size() == 0) begin
        check("unexpected_latch", 64'(bcd_a), 64'hFFFFFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("latch value=%0d cycle=%0d bcd_a=%05h bcd_b=%05h", e.value, cyc, bcd_a, bcd_b);
        check("latency", 64'(cyc), 64'(e.due));
        check("bcd_a", 64'(bcd_a), 64'(to_bcd(e.value)));
        check("bcd_b", 64'(bcd_b), 64'(to_bcd(e.value)));
        check("valid", 64'({valid_a, valid_b}), 64'd3);
        check("hex_a", 64'({a4, a3, a2, a1, a0}), 64'(digits(e.value, 1'b1, 1'b1)));
        check("hex_b", 64'({b4, b3, b2, b1, b0}), 64'(digits(e.value, 1'b0, 1'b0)));
      end
    end
    prev_busy = busy_a;
  end

  task automatic convert(input logic [15:0] v);
    @(negedge clk);
    value_in = v;
    q.push_back('{value: v, due: cyc + 18});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("idle_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'({busy_a, busy_b}), 64'd0);
    check({tag, "_valid"}, 64'({valid_a, valid_b}), 64'd0);
    check({tag, "_bcd"}, 64'({bcd_a, bcd_b}), 64'd0);
    check({tag, "_hex_a"}, 64'({a5, a4, a3, a2, a1, a0}), {22'd0, {6{7'h7F}}});
    check({tag, "_hex_b"}, 64'({b5, b4, b3, b2, b1, b0}), 64'd0);
  endtask

  initial begin
    int busy_cycles;
    int first_due;
    reset    = 1'b0;
    value_in = 16'd1234;
    state_in = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");

    // Release: pending forces a conversion of 1234
    @(negedge clk);
    #2;
    reset = 1'b1;
    q.push_back('{value: 16'd1234, due: cyc + 18});
    wait_idle();

    state_in = 3'd5;
    convert(16'd8);
    wait_idle();
    check("hex5_a", 64'(a5), 64'(seg(5, 1'b0, 1'b1)));
    check("hex5_b", 64'(b5), 64'(seg(5, 1'b0, 1'b0)));

    state_in = 3'd2;
    convert(16'd610);
    wait_idle();
    check("hex5_a_2", 64'(a5), 64'(seg(2, 1'b0, 1'b1)));
    convert(16'd65535);
    wait_idle();
    convert(16'd0);
    wait_idle();

    // Change value mid-conversion: first latches 377, then 987 exactly 18 edges later
    convert(16'd377);
    first_due = q[0].due;
    repeat (6) @(negedge clk);
    value_in = 16'd987;
    q.push_back('{value: 16'd987, due: first_due + 18});
    wait_idle();

    busy_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy_a || busy_b) busy_cycles++;
    end
    check("quiet_busy", 64'(busy_cycles), 64'd0);

    // Async reset during shift 10, then recovery of the present value
    convert(16'd4321);
    repeat (11) @(negedge clk);
    q.delete();
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    q.push_back('{value: 16'd4321, due: cyc + 18});
    wait_idle();

    check("sb_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
